regfile_writeback_queue: RTL
============================

// Module: regfile_writeback_queue
// PURPOSE
//   Write-side initiator for the 32x32 register file. Sits at the end of the MEM/WB
//   stage and accepts results over a valid/ready handshake into a DEPTH-entry FIFO.
//   It drains the FIFO at most one entry per clock onto the register file write port
//   (regWrite/writeReg/writeData). It also forwards pending, not-yet-written values
//   to two read addresses, so readers do not race the register file update.
// PARAMETERS
//   DEPTH   4    FIFO entries (power of two, >=2)
//   AW      2    log2(DEPTH), pointer width
// PORTS
//   clk        in   1   system clock; all state updates on posedge
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   producer has a result
//   in_ready   out  1   queue can accept (count < DEPTH)
//   in_reg     in   5   destination register
//   in_data    in   32  result value
//   drain_en   in   1   write port may be used this cycle (0 = hold, e.g. during init)
//   regWrite   out  1   register file write enable (registered)
//   writeReg   out  5   register file write address (registered)
//   writeData  out  32  register file write data (registered)
//   fwd_addr1  in   5   forwarding lookup address, port 1
//   fwd_addr2  in   5   forwarding lookup address, port 2
//   fwd_hit1   out  1   a pending write to fwd_addr1 exists (combinational)
//   fwd_hit2   out  1   a pending write to fwd_addr2 exists (combinational)
//   fwd_data1  out  32  newest pending value for fwd_addr1 (0 when no hit)
//   fwd_data2  out  32  newest pending value for fwd_addr2 (0 when no hit)
//   count      out  AW+1 occupied FIFO entries
//   empty      out  1   count==0 and regWrite==0
// BEHAVIOUR
// - Reset (async, rst=1):
//   - count=0 and all pointers=0.
//   - regWrite=0, writeReg=0, writeData=0.
//   - All pending entries are discarded, including when reset hits mid-drain.
// - Accept:
//   - A transfer occurs at posedge when in_valid && in_ready.
//   - in_ready = (count<DEPTH) and depends only on current count, never on this
//     cycle's dequeue.
// - Register 0:
//   - A transfer with in_reg==0 completes the handshake but is not stored.
//   - count is unchanged by such a transfer.
// - Dequeue:
//   - At posedge, if drain_en && count>0, the head entry moves to writeReg/writeData.
//   - regWrite=1 for exactly that following cycle; otherwise regWrite=0 next cycle.
//   - writeReg/writeData hold their last value while regWrite=0.
// - Latency:
//   - Accepted at edge N into an empty queue with drain_en=1: regWrite=1 during
//     cycle N+1 -> N+2.
//   - The register file commits at edge N+2.
// - Simultaneous events:
//   - Enqueue and dequeue in the same cycle: count unchanged, FIFO order preserved.
//   - Pointers wrap modulo DEPTH.
// - Full: in_ready=0 and in_valid is ignored; no overwrite, no loss.
// - drain_en=0: FIFO holds; accepts continue until full.
// - Forwarding (per port):
//   - Search set is the valid FIFO entries plus the output register while
//     regWrite=1.
//   - Newest match wins: youngest FIFO entry > older entries > output register.
//   - fwd_addr==0 never hits.
// - Ordering: writes to the same register commit in acceptance order.
// TESTING
// - Reset, then accept (r5,0x11111111) with drain_en=1 -> regWrite=1, writeReg=5,
//   writeData=0x11111111 exactly one cycle, then regWrite=0 and empty=1.
// - drain_en=0, push 5 entries r1..r5 -> first 4 accepted, count=4, in_ready=0;
//   5th held until drain_en=1, then writes r1,r2,r3,r4,r5 on consecutive cycles.
// - Push (r7,0xA), then (r7,0xB), drain_en=0, fwd_addr1=7 -> fwd_hit1=1,
//   fwd_data1=0xB. Drain both -> writes 0xA then 0xB; hit drops after the 0xB
//   regWrite cycle.
// - Push (r0,0xDEAD) -> handshake completes, count stays 0, no regWrite.
//   fwd_addr2=0 -> fwd_hit2=0.
// - Full queue with drain_en=1 and in_valid held -> steady one write and one accept
//   per cycle after the first drain. Pointer wrap verified over 3*DEPTH entries.
// - Assert rst while count=3 and regWrite=1 -> regWrite=0, count=0 immediately,
//   with no posedge required; no stale writes after release.

Source files
------------

// File: rtl/regfile_writeback_queue.sv
// ============================================================================
// regfile_writeback_queue
// ----------------------------------------------------------------------------
// Write-side initiator for the 32x32 register file, placed at the end of the
// MEM/WB stage. Results arrive over a valid/ready handshake and are buffered in
// a DEPTH-entry FIFO. The FIFO drains at most one entry per clock onto the
// register file write port through a registered output stage. Values that are
// accepted but not yet committed are forwarded to two lookup ports, so readers
// never race the register file update.
//
// Ports
//   clk        : system clock, all state updates on the rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : producer has a result to hand over
//   in_ready   : queue can accept a result (count < DEPTH)
//   in_reg     : destination register of the offered result
//   in_data    : value of the offered result
//   drain_en   : write port may be used this cycle (0 holds the FIFO)
//   regWrite   : register file write enable (registered)
//   writeReg   : register file write address (registered)
//   writeData  : register file write data (registered)
//   fwd_addr1  : forwarding lookup address, port 1
//   fwd_addr2  : forwarding lookup address, port 2
//   fwd_hit1   : a pending write to fwd_addr1 exists
//   fwd_hit2   : a pending write to fwd_addr2 exists
//   fwd_data1  : newest pending value for fwd_addr1 (0 when no hit)
//   fwd_data2  : newest pending value for fwd_addr2 (0 when no hit)
//   count      : number of occupied FIFO entries
//   empty      : nothing pending at all (count == 0 and regWrite == 0)
// ============================================================================
module regfile_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_reg,
    input  logic [31:0]   in_data,
    input  logic          drain_en,
    output logic          regWrite,
    output logic [4:0]    writeReg,
    output logic [31:0]   writeData,
    input  logic [4:0]    fwd_addr1,
    input  logic [4:0]    fwd_addr2,
    output logic          fwd_hit1,
    output logic          fwd_hit2,
    output logic [31:0]   fwd_data1,
    output logic [31:0]   fwd_data2,
    output logic [AW:0]   count,
    output logic          empty
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    // FIFO storage; validity of a slot is implied by head/count, so the
    // storage itself needs no reset.
    logic [4:0]    entry_reg  [DEPTH];
    logic [31:0]   entry_data [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;

    logic          push;
    logic          pop;

    // Two lookup ports handled by one loop.
    logic [4:0]    lookup_addr [2];
    logic          lookup_hit  [2];
    logic [31:0]   lookup_data [2];

    // Readiness depends only on the registered count, never on a dequeue
    // happening in the same cycle, so there is no ready/drain combinational path.
    assign in_ready = (count < FULL_COUNT);

    // A transfer to r0 completes the handshake but is dropped on the floor.
    assign push = in_valid && in_ready && (in_reg != 5'd0);
    assign pop  = drain_en && (count != '0);

    assign empty = (count == '0) && !regWrite;

    always_ff @(posedge clk) begin
        if (push) begin
            entry_reg[tail]  <= in_reg;
            entry_data[tail] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output stage: regWrite pulses for exactly the cycle after a dequeue;
    // address and data hold their last value while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            regWrite <= pop;
            if (pop) begin
                writeReg  <= entry_reg[head];
                writeData <= entry_data[head];
            end
        end
    end

    assign lookup_addr[0] = fwd_addr1;
    assign lookup_addr[1] = fwd_addr2;

    // Search from oldest to newest so a later match overrides an earlier one:
    // the output register is the oldest pending write, then FIFO entries from
    // head (oldest) towards tail (youngest). Address 0 never hits.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            lookup_hit[p]  = 1'b0;
            lookup_data[p] = '0;
            if (lookup_addr[p] != 5'd0) begin
                if (regWrite && (writeReg == lookup_addr[p])) begin
                    lookup_hit[p]  = 1'b1;
                    lookup_data[p] = writeData;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (((AW+1)'(i) < count) &&
                        (entry_reg[head + AW'(i)] == lookup_addr[p])) begin
                        lookup_hit[p]  = 1'b1;
                        lookup_data[p] = entry_data[head + AW'(i)];
                    end
                end
            end
        end
    end

    assign fwd_hit1  = lookup_hit[0];
    assign fwd_hit2  = lookup_hit[1];
    assign fwd_data1 = lookup_data[0];
    assign fwd_data2 = lookup_data[1];

endmodule
